// File: rtl/irq_aggregator_pkg.sv
// irq_aggregator_pkg: shared register offsets and field positions for irq_aggregator.
//   Exposes register byte offsets, the CLAIM valid bit index, the CTRL global-enable
//   bit index and the OKAY response code. No ports.
package irq_aggregator_pkg;
    localparam logic [7:0] ADDR_PENDING    = 8'h00;
    localparam logic [7:0] ADDR_ENABLE     = 8'h04;
    localparam logic [7:0] ADDR_MODE       = 8'h08;
    localparam logic [7:0] ADDR_CLAIM      = 8'h0C;
    localparam logic [7:0] ADDR_CTRL       = 8'h10;
    localparam int         CLAIM_VALID_BIT = 31;
    localparam int         CTRL_GEN_BIT    = 0;
    localparam logic [1:0] RESP_OKAY       = 2'b00;
endpackage

// File: rtl/irq_prio_enc.sv
// irq_prio_enc: combinational lowest-index-first priority encoder.
//   i_req   [NUM_SRC]  request vector
//   o_valid            any request set
//   o_id    [ID_W]     index of the lowest set request (0 when none)
module irq_prio_enc
    import irq_aggregator_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_id
);
    // Scanning from the top down lets the lowest index overwrite last.
    always_comb begin
        o_valid = 1'b0;
        o_id    = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_valid = 1'b1;
                o_id    = ID_W'(i);
            end
        end
    end
endmodule

// File: rtl/irq_aggregator.sv
// irq_aggregator: collects NUM_SRC interrupt lines into one registered CPU interrupt,
//   with per-source pending/enable/mode state configured over an AXI-lite subset.
//   clk, rst (async, active-low)
//   src_i [NUM_SRC]            raw level interrupt lines
//   cfg_aw*/cfg_w*/cfg_b*      write channel (only wstrb=4'hF writes take effect)
//   cfg_ar*/cfg_r*             read channel
//   irq_o                      GLOBAL_EN & |(pending & ENABLE), registered
//   Build option IRQ_AGGREGATOR_SYNC_EN: 2-flop synchronizer on src_i (+2 cycles latency).
module irq_aggregator
    import irq_aggregator_pkg::*;
#(
    parameter int NUM_SRC = 8,
    parameter int ID_W    = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_SRC-1:0] src_i,
    input  logic               cfg_awvalid_i,
    input  logic [31:0]        cfg_awaddr_i,
    input  logic               cfg_wvalid_i,
    input  logic [31:0]        cfg_wdata_i,
    input  logic [3:0]         cfg_wstrb_i,
    input  logic               cfg_bready_i,
    input  logic               cfg_arvalid_i,
    input  logic [31:0]        cfg_araddr_i,
    input  logic               cfg_rready_i,
    output logic               cfg_awready_o,
    output logic               cfg_wready_o,
    output logic               cfg_bvalid_o,
    output logic [1:0]         cfg_bresp_o,
    output logic               cfg_arready_o,
    output logic               cfg_rvalid_o,
    output logic [31:0]        cfg_rdata_o,
    output logic [1:0]         cfg_rresp_o,
    output logic               irq_o
);
    logic [NUM_SRC-1:0] w_src;
`ifdef IRQ_AGGREGATOR_SYNC_EN
    logic [NUM_SRC-1:0] r_sync1, r_sync2;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src_i;
            r_sync2 <= r_sync1;
        end
    end
    assign w_src = r_sync2;
`else
    assign w_src = src_i;
`endif

    logic [NUM_SRC-1:0] r_src_d, r_edge, r_en, r_mode;
    logic               r_gen, r_irq, r_bvalid, r_rvalid;
    logic [31:0]        r_rdata;
    logic [NUM_SRC-1:0] w_pend, w_w1c, w_claim_clr, w_edge_nxt;
    logic               w_wr, w_we, w_rd, w_cl_valid, w_unused;
    logic [ID_W-1:0]    w_cl_id;
    logic [7:0]         w_waddr, w_raddr;
    logic [31:0]        w_claim_word, w_rdata_mux;

    // Level sources report the registered line so both modes share the 2-cycle latency.
    assign w_pend  = (r_mode & r_edge) | (~r_mode & r_src_d);
    assign w_waddr = cfg_awaddr_i[7:0];
    assign w_raddr = cfg_araddr_i[7:0];
    assign w_wr    = cfg_awvalid_i & cfg_wvalid_i & ~r_bvalid;
    assign w_we    = w_wr & (cfg_wstrb_i == 4'hF);
    assign w_rd    = cfg_arvalid_i & ~r_rvalid;

    irq_prio_enc #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_enc (
        .i_req   (w_pend & r_en),
        .o_valid (w_cl_valid),
        .o_id    (w_cl_id)
    );

    assign w_w1c       = (w_we && w_waddr == ADDR_PENDING) ? cfg_wdata_i[NUM_SRC-1:0] : '0;
    assign w_claim_clr = (w_rd && w_raddr == ADDR_CLAIM && w_cl_valid) ? NUM_SRC'(1) << w_cl_id : '0;
    // A new rising edge beats any clear in the same cycle; level-mode bits never latch.
    assign w_edge_nxt  = ((r_edge & ~(w_w1c | w_claim_clr)) | (w_src & ~r_src_d)) & r_mode;

    always_comb begin
        w_claim_word                  = 32'(w_cl_id);
        w_claim_word[CLAIM_VALID_BIT] = w_cl_valid;
        w_rdata_mux = (w_raddr == ADDR_PENDING) ? 32'(w_pend) :
                      (w_raddr == ADDR_ENABLE)  ? 32'(r_en)   :
                      (w_raddr == ADDR_MODE)    ? 32'(r_mode) :
                      (w_raddr == ADDR_CLAIM)   ? w_claim_word :
                      (w_raddr == ADDR_CTRL)    ? 32'(r_gen) << CTRL_GEN_BIT : '0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src_d  <= '0;
            r_edge   <= '0;
            r_en     <= '0;
            r_mode   <= '0;
            r_gen    <= 1'b0;
            r_irq    <= 1'b0;
            r_bvalid <= 1'b0;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else begin
            r_src_d  <= w_src;
            r_edge   <= w_edge_nxt;
            r_irq    <= r_gen & |(w_pend & r_en);
            r_bvalid <= w_wr | (r_bvalid & ~cfg_bready_i);
            r_rvalid <= w_rd | (r_rvalid & ~cfg_rready_i);
            if (w_rd) r_rdata <= w_rdata_mux;
            if (w_we && w_waddr == ADDR_ENABLE) r_en <= cfg_wdata_i[NUM_SRC-1:0];
            if (w_we && w_waddr == ADDR_MODE) r_mode <= cfg_wdata_i[NUM_SRC-1:0];
            if (w_we && w_waddr == ADDR_CTRL) r_gen <= cfg_wdata_i[CTRL_GEN_BIT];
        end
    end

    // Ready strobes are combinational handshakes, held low while in reset.
    assign cfg_awready_o = rst & w_wr;
    assign cfg_wready_o  = rst & w_wr;
    assign cfg_arready_o = rst & w_rd;
    assign cfg_bvalid_o  = r_bvalid;
    assign cfg_rvalid_o  = r_rvalid;
    assign cfg_rdata_o   = r_rdata;
    assign cfg_bresp_o   = RESP_OKAY;
    assign cfg_rresp_o   = RESP_OKAY;
    assign irq_o         = r_irq;
    assign w_unused      = ^{cfg_awaddr_i[31:8], cfg_araddr_i[31:8], cfg_wdata_i[31:NUM_SRC]};
endmodule

// File: tb/tb_irq_aggregator.sv
// tb_irq_aggregator: directed scenarios plus randomized bus/source traffic checked against
//   a per-source behavioural model of the interrupt aggregator.
module tb_irq_aggregator;
    localparam int N  = 8;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  src = '0;
    logic          awvalid = 1'b0, wvalid = 1'b0, bready = 1'b1, arvalid = 1'b0, rready = 1'b1;
    logic [31:0]   awaddr = '0, wdata = '0, araddr = '0;
    logic [3:0]    wstrb = 4'hF;
    logic          awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]    bresp, rresp;
    logic [31:0]   rdata, d;

    always #5 clk = ~clk;

    irq_aggregator #(.NUM_SRC(N), .ID_W(IW)) dut (
        .clk(clk), .rst(rst), .src_i(src),
        .cfg_awvalid_i(awvalid), .cfg_awaddr_i(awaddr), .cfg_wvalid_i(wvalid),
        .cfg_wdata_i(wdata), .cfg_wstrb_i(wstrb), .cfg_bready_i(bready),
        .cfg_arvalid_i(arvalid), .cfg_araddr_i(araddr), .cfg_rready_i(rready),
        .cfg_awready_o(awready), .cfg_wready_o(wready), .cfg_bvalid_o(bvalid),
        .cfg_bresp_o(bresp), .cfg_arready_o(arready), .cfg_rvalid_o(rvalid),
        .cfg_rdata_o(rdata), .cfg_rresp_o(rresp), .irq_o(irq)
    );

    int n_vec = 0, n_err = 0;

    bit          m_srcd[N], m_edge[N], m_en[N], m_mode[N];
    bit          m_gen, m_irq, m_bv, m_rv;
    logic [31:0] m_rdata;

    function automatic bit pend(int i);
        return m_mode[i] ? m_edge[i] : m_srcd[i];
    endfunction

    function automatic int claim_id();
        for (int i = 0; i < N; i++) if (pend(i) && m_en[i]) return i;
        return -1;
    endfunction

    function automatic logic [31:0] reg_val(logic [7:0] a);
        logic [31:0] v = '0;
        int id;
        for (int i = 0; i < N; i++) begin
            if (a == 8'h00) v[i] = pend(i);
            if (a == 8'h04) v[i] = m_en[i];
            if (a == 8'h08) v[i] = m_mode[i];
        end
        if (a == 8'h0C) begin
            id = claim_id();
            v = (id < 0) ? 32'h0 : 32'h8000_0000 + 32'(id);
        end
        if (a == 8'h10) v = 32'(m_gen);
        return v;
    endfunction

    function automatic logic [31:0] pick_addr();
        int k = $urandom_range(0, 6);
        return (k < 5) ? 32'(k * 4) : (k == 5) ? 32'h40 : 32'($urandom);
    endfunction

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_srcd[i] = 0; m_edge[i] = 0; m_en[i] = 0; m_mode[i] = 0;
        end
        m_gen = 0; m_irq = 0; m_bv = 0; m_rv = 0; m_rdata = '0;
    endtask

    // One clock: check combinational handshakes, predict the edge, then check registered outputs.
    task automatic step();
        bit wr, rd, we, any, rise, clr;
        bit nx_edge[N];
        int cid;
        logic [31:0] nx_rdata;
        #1;
        wr = awvalid && wvalid && !m_bv;
        rd = arvalid && !m_rv;
        we = wr && wstrb == 4'hF;
        chk("awready", awready, wr);
        chk("wready", wready, wr);
        chk("arready", arready, rd);
        cid = claim_id();
        nx_rdata = rd ? reg_val(araddr[7:0]) : m_rdata;
        any = 0;
        for (int i = 0; i < N; i++) begin
            if (pend(i) && m_en[i]) any = 1;
            rise = src[i] && !m_srcd[i];
            clr = (we && awaddr[7:0] == 8'h00 && wdata[i]) || (rd && araddr[7:0] == 8'h0C && cid == i);
            nx_edge[i] = m_mode[i] && (rise || (m_edge[i] && !clr));
        end
        @(posedge clk);
        #1;
        m_irq = m_gen && any;
        for (int i = 0; i < N; i++) begin
            m_srcd[i] = src[i];
            m_edge[i] = nx_edge[i];
            if (we && awaddr[7:0] == 8'h04) m_en[i] = wdata[i];
            if (we && awaddr[7:0] == 8'h08) m_mode[i] = wdata[i];
        end
        if (we && awaddr[7:0] == 8'h10) m_gen = wdata[0];
        m_bv = wr || (m_bv && !bready);
        m_rv = rd || (m_rv && !rready);
        m_rdata = nx_rdata;
        chk("irq", irq, m_irq);
        chk("bvalid", bvalid, m_bv);
        chk("rvalid", rvalid, m_rv);
        chk("rdata", rdata, m_rdata);
        chk("bresp", bresp, 0);
        chk("rresp", rresp, 0);
    endtask

    task automatic wr_reg(logic [31:0] a, logic [31:0] v);
        awvalid = 1; wvalid = 1; awaddr = a; wdata = v; wstrb = 4'hF;
        step();
        awvalid = 0; wvalid = 0;
        step();
    endtask

    task automatic rd_reg(logic [31:0] a, output logic [31:0] v);
        arvalid = 1; araddr = a;
        step();
        arvalid = 0;
        v = rdata;
        step();
    endtask

    initial begin
        model_reset();
        #12;
        chk("rst awready", awready, 0);
        chk("rst wready", wready, 0);
        chk("rst arready", arready, 0);
        chk("rst bvalid", bvalid, 0);
        chk("rst rvalid", rvalid, 0);
        chk("rst rdata", rdata, 0);
        chk("rst irq", irq, 0);
        rst = 1;
        @(posedge clk);
        #1;

        // Level source 0: irq follows src with 2 cycles of latency each way.
        wr_reg(32'h04, 32'h1);
        wr_reg(32'h10, 32'h1);
        wr_reg(32'h08, 32'h0);
        src[0] = 1;
        step();
        chk("t1 rise+1", irq, 0);
        step();
        chk("t1 rise+2", irq, 1);
        src[0] = 0;
        step();
        chk("t1 fall+1", irq, 1);
        step();
        chk("t1 fall+2", irq, 0);

        // Edge source 1 with W1C.
        wr_reg(32'h08, 32'h2);
        wr_reg(32'h04, 32'h2);
        src[1] = 1;
        step();
        src[1] = 0;
        step();
        chk("t2 irq set", irq, 1);
        rd_reg(32'h00, d);
        chk("t2 pending", d, 32'h2);
        wr_reg(32'h00, 32'h2);
        chk("t2 irq clr", irq, 0);
        rd_reg(32'h00, d);
        chk("t2 pending clr", d, 32'h0);

        // Claim order: lowest index first, then empty.
        wr_reg(32'h08, 32'hFF);
        wr_reg(32'h04, 32'hFF);
        src[3] = 1; src[1] = 1;
        step();
        src = '0;
        step();
        rd_reg(32'h0C, d);
        chk("t3 claim1", d, 32'h8000_0001);
        rd_reg(32'h0C, d);
        chk("t3 claim3", d, 32'h8000_0003);
        rd_reg(32'h0C, d);
        chk("t3 claim none", d, 32'h0);

        // W1C collides with a new rising edge: set wins.
        wr_reg(32'h08, 32'h4);
        src[2] = 1;
        step();
        src[2] = 0;
        step();
        awvalid = 1; wvalid = 1; awaddr = 32'h00; wdata = 32'h4; src[2] = 1;
        step();
        awvalid = 0; wvalid = 0; src[2] = 0;
        step();
        rd_reg(32'h00, d);
        chk("t4 collide", d, 32'h4);

        // Global enable gates irq; unmapped read returns 0.
        wr_reg(32'h04, 32'h4);
        wr_reg(32'h10, 32'h0);
        step();
        step();
        chk("t5 gen off", irq, 0);
        wr_reg(32'h10, 32'h1);
        chk("t5 gen on", irq, 1);
        rd_reg(32'h40, d);
        chk("t5 unmapped", d, 32'h0);

        // Asynchronous reset in the middle of a write response with irq high.
        bready = 0;
        awvalid = 1; wvalid = 1; awaddr = 32'h04; wdata = 32'h4;
        step();
        awvalid = 0; wvalid = 0;
        chk("t6 bvalid held", bvalid, 1);
        chk("t6 irq held", irq, 1);
        #2 rst = 0;
        #1;
        chk("t6 bvalid", bvalid, 0);
        chk("t6 irq", irq, 0);
        chk("t6 rvalid", rvalid, 0);
        chk("t6 rdata", rdata, 0);
        model_reset();
        bready = 1;
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        for (int a = 0; a <= 16; a += 4) begin
            rd_reg(32'(a), d);
            chk("t6 reg zero", d, 32'h0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 1500; c++) begin
            src     = src ^ N'($urandom & $urandom & $urandom);
            awvalid = $urandom_range(0, 3) == 0;
            wvalid  = awvalid;
            awaddr  = pick_addr();
            wdata   = $urandom;
            wstrb   = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            bready  = $urandom_range(0, 3) != 0;
            arvalid = $urandom_range(0, 2) == 0;
            araddr  = pick_addr();
            rready  = $urandom_range(0, 3) != 0;
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
